hazard_ctrl_unit: RTL

Parametrised load-use stall and branch-flush controller for the in-order pipeline, sitting between the ID stage decoder and the PC / IF/ID / ID/EX registers. It generalises single-bubble load-use detection to multi-cycle load latency and multi-cycle fetch flush. It also adds x0 exclusion, per-operand use qualification, an explicit stall/flush priority rule, and saturating stall/flush event counters for performance monitoring.

---
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_ctrl_unit.sv | 123 ++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle between the ID-stage decoder and the pipeline
// register enables.
//   master: decoder / pipeline side, drives operand and EX-stage info
//   slave : hazard_ctrl_unit, drives enables, flush and event counters
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic [REG_AW-1:0] Rs1_IFID;
  logic [REG_AW-1:0] Rs2_IFID;
  logic              Rs1_used_IFID;
  logic              Rs2_used_IFID;
  logic [REG_AW-1:0] Rd_IDEX;
  logic              MemRead_IDEX;
  logic              IDControlBranch;
  logic              PCWrite;
  logic              IFIDWrite;
  logic              cont_mux_sel;
  logic              IF_Flush;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output Rs1_IFID, Rs2_IFID, Rs1_used_IFID, Rs2_used_IFID,
    output Rd_IDEX, MemRead_IDEX, IDControlBranch,
    input  PCWrite, IFIDWrite, cont_mux_sel, IF_Flush,
    input  stall_count, flush_count
  );

  modport slave (
    input  Rs1_IFID, Rs2_IFID, Rs1_used_IFID, Rs2_used_IFID,
    input  Rd_IDEX, MemRead_IDEX, IDControlBranch,
    output PCWrite, IFIDWrite, cont_mux_sel, IF_Flush,
    output stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Load-use stall and branch-flush controller with multi-cycle load latency,
// multi-cycle fetch flush and saturating stall/flush event counters.
//   clk, rst_n : clock, synchronous active-low reset
//   hz (slave) : ID/EX hazard inputs in; PCWrite, IFIDWrite, cont_mux_sel,
//                IF_Flush (combinational) and stall_count/flush_count out
module hazard_ctrl_unit #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  localparam int unsigned MAX_CYC = (LOAD_LAT > FLUSH_DEPTH) ? LOAD_LAT : FLUSH_DEPTH;
  localparam int unsigned REM_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_e;

  state_e             state_q, state_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic hazard_c;
  logic pc_write_c;
  logic ifid_write_c;
  logic mux_sel_c;
  logic if_flush_c;

  // Load-use hazard: x0 never carries a dependency; unused operands are ignored.
  always_comb begin
    hazard_c = hz.MemRead_IDEX && (hz.Rd_IDEX != '0) &&
               ((hz.Rs1_used_IFID && (hz.Rs1_IFID == hz.Rd_IDEX)) ||
                (hz.Rs2_used_IFID && (hz.Rs2_IFID == hz.Rd_IDEX)));
  end

  // Next-state and output decode; hazard wins over a same-cycle branch.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    pc_write_c   = 1'b1;
    ifid_write_c = 1'b1;
    mux_sel_c    = 1'b0;
    if_flush_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hazard_c) begin
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          mux_sel_c    = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = STALL;
            rem_d   = REM_W'(LOAD_LAT - 1);
          end
        end else if (hz.IDControlBranch) begin
          if_flush_c = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_d = FLUSH;
            rem_d   = REM_W'(FLUSH_DEPTH - 1);
          end
        end
      end
      STALL: begin
        pc_write_c   = 1'b0;
        ifid_write_c = 1'b0;
        mux_sel_c    = 1'b1;
        rem_d        = rem_q - REM_W'(1);
        if (rem_q == REM_W'(1)) state_d = IDLE;
      end
      FLUSH: begin
        // ID holds squashed instructions, so hazard/branch inputs are ignored.
        if_flush_c = 1'b1;
        rem_d      = rem_q - REM_W'(1);
        if (rem_q == REM_W'(1)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
    // Reset forces pass values regardless of state.
    if (!rst_n) begin
      pc_write_c   = 1'b1;
      ifid_write_c = 1'b1;
      mux_sel_c    = 1'b0;
      if_flush_c   = 1'b0;
    end
  end

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (mux_sel_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (if_flush_c && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.PCWrite      = pc_write_c;
  assign hz.IFIDWrite    = ifid_write_c;
  assign hz.cont_mux_sel = mux_sel_c;
  assign hz.IF_Flush     = if_flush_c;
  // Counters read zero for the whole time reset is held, not just after the edge.
  assign hz.stall_count  = rst_n ? stall_cnt_q : '0;
  assign hz.flush_count  = rst_n ? flush_cnt_q : '0;

endmodule
